vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Produces the scan-position and sync stream consumed by every sprite and tile mapper: DrawX, DrawY, blank, plus the HS/VS sent to the VGA DAC.
- Fixed 640x480@60 Hz timing from the 25 MHz vga_clk.
- Also provides sync/blank copies delayed to match mapper pipeline latency, and a frame strobe and frame counter for sprite animation.

Parameters:
- PIPE_DELAY, 2, cycles of delay on hs_d/vs_d/blank_d. Default matches synchronous ROM (1) plus mapper output register (1). Legal range 0..4.
- FRAME_CNT_W, 8, width of frame_count.

Ports:
- vga_clk  input  1  pixel clock, 25 MHz; the only clock.
- reset  input  1  asynchronous, active-high reset.
- DrawX  output  10  current horizontal count, 0..799.
- DrawY  output  10  current vertical count, 0..524.
- blank  output  1  1 = active video (DrawX<640 and DrawY<480); 0 = blanking.
- hs  output  1  horizontal sync, active-low, aligned with DrawX/DrawY.
- vs  output  1  vertical sync, active-low, aligned with DrawX/DrawY.
- hs_d  output  1  hs delayed PIPE_DELAY cycles.
- vs_d  output  1  vs delayed PIPE_DELAY cycles.
- blank_d  output  1  blank delayed PIPE_DELAY cycles.
- frame_start  output  1  one-cycle strobe at the start of each new frame.
- frame_count  output  FRAME_CNT_W  frames completed since reset; wraps.

Behaviour:
- Horizontal: 640 visible, 16 front porch, 96 sync, 48 back porch; 800 total.
- Vertical: 480 visible, 10 front porch, 2 sync, 33 back porch; 525 total.
- DrawX and DrawY are the counter registers themselves.
  - DrawX increments every cycle; at 799 it wraps to 0.
  - DrawY increments only on the DrawX 799->0 wrap; at 524 it wraps to 0 on that same edge.
- blank, hs and vs are registered from next-state counter values, so they are valid in the same cycle as the matching DrawX/DrawY. There is no combinational path from counters to outputs.
  - blank = (DrawX<640) && (DrawY<480).
  - hs = 0 iff 656<=DrawX<=751 (96 cycles).
  - vs = 0 iff 490<=DrawY<=491 (2 full lines = 1600 cycles, 800 per line).
- Delay line:
  - Shift register of depth PIPE_DELAY on {hs, vs, blank}.
  - Reset fill value is hs=1, vs=1, blank=0.
  - PIPE_DELAY=0 makes hs_d/vs_d/blank_d wire-equal to hs/vs/blank.
- frame_start:
  - Registered; high for exactly one cycle, the cycle where DrawX=0 and DrawY=0 as the result of a counter wrap.
  - Not asserted for the first frame after reset release.
- frame_count:
  - Increments on the same edge that raises frame_start.
  - Wraps 2^FRAME_CNT_W-1 -> 0 with no saturation.
- Reset values (asynchronous, immediate, valid at any point in a line or frame):
  - DrawX=0, DrawY=0, blank=1, hs=1, vs=1.
  - hs_d=1, vs_d=1, blank_d=0, frame_start=0, frame_count=0.
  - The first clock edge after release advances DrawX to 1.
- Width rules:
  - Counters are 10 bits; comparisons are unsigned against package constants.
  - No value above 799/524 is ever reachable.
  - Any illegal counter value (e.g. from SEU) wraps to 0 on the next edge.

Decomposition:
- Package vga_timing_pkg holds:
  - localparams H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800.
  - localparams V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525.
  - Derived H_SYNC_START/END and V_SYNC_START/END.
  - typedef logic [9:0] coord_t, shared with all mapper modules.
- One sub-module, sync_delay_line, parameterized by DEPTH, WIDTH and reset value; it implements the PIPE_DELAY pipeline.

Test Plan:
- Reset mid-line: assert reset when DrawX=300, DrawY=100 -> outputs reach reset values before the next edge, with no clock needed; after release, DrawX sequence is 0,1,2 and frame_count=0.
- Line timing: over one line -> blank=1 at DrawX=639 and 0 at 640; hs low exactly for DrawX 656..751 (96 cycles); DrawX 799->0 coincides with DrawY incrementing by 1.
- Frame timing: run 2 frames -> vs low exactly on DrawY 490..491 (1600 cycles); frame_start pulses are 420000 cycles apart; no frame_start in the first frame after reset.
- Frame counter wrap with FRAME_CNT_W=8: run 256 frames -> frame_count goes 255->0 on the edge raising frame_start.
- Delay alignment:
  - PIPE_DELAY=2: hs_d falls 2 cycles after hs, i.e. while DrawX=658; blank_d falls while DrawX=642.
  - PIPE_DELAY=0: hs_d==hs, vs_d==vs and blank_d==blank in every cycle.
- Reset during vsync (DrawY=491) -> vs returns to 1 immediately; hs_d/vs_d stay 1 and blank_d stays 0 for PIPE_DELAY cycles after release, then track the delayed stream.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 Hz timing constants and shared scan types.
// Imported by the timing generator and by every sprite/tile mapper.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam coord_t H_VISIBLE = 10'd640;
    localparam coord_t H_FP      = 10'd16;
    localparam coord_t H_SYNC    = 10'd96;
    localparam coord_t H_BP      = 10'd48;
    localparam coord_t H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam coord_t H_LAST    = H_TOTAL - 10'd1;

    localparam coord_t V_VISIBLE = 10'd480;
    localparam coord_t V_FP      = 10'd10;
    localparam coord_t V_SYNC    = 10'd2;
    localparam coord_t V_BP      = 10'd33;
    localparam coord_t V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam coord_t V_LAST    = V_TOTAL - 10'd1;

    localparam coord_t H_SYNC_START = H_VISIBLE + H_FP;
    localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;
    localparam coord_t V_SYNC_START = V_VISIBLE + V_FP;
    localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

    function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// sync_delay_line: fixed-depth shift register with a programmable reset fill.
// Depth 0 collapses to a plain wire.
module sync_delay_line #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [DEPTH];

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_pipe[i] <= RST_VAL;
                    end
                end else begin
                    r_pipe[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign o_q = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 scan counters, registered sync/blank,
// pipeline-matched delayed copies, and a frame strobe/counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int PIPE_DELAY  = 2,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   vga_clk,
    input  logic                   reset,
    output logic [9:0]             DrawX,
    output logic [9:0]             DrawY,
    output logic                   blank,
    output logic                   hs,
    output logic                   vs,
    output logic                   hs_d,
    output logic                   vs_d,
    output logic                   blank_d,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    coord_t                 r_x;
    coord_t                 r_y;
    logic                   r_blank;
    logic                   r_hs;
    logic                   r_vs;
    logic                   r_fs;
    logic [FRAME_CNT_W-1:0] r_fcnt;

    coord_t w_x_nxt;
    coord_t w_y_nxt;
    logic   w_x_last;
    logic   w_frame_wrap;
    sync_t  w_sync;
    sync_t  w_sync_d;

    // ">=" rather than "==" so any out-of-range value recovers in one edge
    always_comb begin
        w_x_last     = (r_x >= H_LAST);
        w_x_nxt      = w_x_last ? '0 : r_x + 10'd1;
        w_frame_wrap = w_x_last && (r_y >= V_LAST);
        if (w_x_last) begin
            w_y_nxt = (r_y >= V_LAST) ? '0 : r_y + 10'd1;
        end else begin
            w_y_nxt = (r_y > V_LAST) ? '0 : r_y;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_blank <= 1'b1;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_fs    <= 1'b0;
            r_fcnt  <= '0;
        end else begin
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_blank <= (w_x_nxt < H_VISIBLE) && (w_y_nxt < V_VISIBLE);
            r_hs    <= !in_range(w_x_nxt, H_SYNC_START, H_SYNC_END);
            r_vs    <= !in_range(w_y_nxt, V_SYNC_START, V_SYNC_END);
            r_fs    <= w_frame_wrap;
            r_fcnt  <= w_frame_wrap ? r_fcnt + 1'b1 : r_fcnt;
        end
    end

    assign w_sync = '{hs: r_hs, vs: r_vs, blank: r_blank};

    sync_delay_line #(
        .DEPTH   (PIPE_DELAY),
        .WIDTH   (3),
        .RST_VAL (SYNC_IDLE)
    ) u_dly (
        .i_clk (vga_clk),
        .i_rst (reset),
        .i_d   (w_sync),
        .o_q   (w_sync_d)
    );

    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign blank       = r_blank;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign hs_d        = w_sync_d.hs;
    assign vs_d        = w_sync_d.vs;
    assign blank_d     = w_sync_d.blank;
    assign frame_start = r_fs;
    assign frame_count = r_fcnt;

endmodule
